// File: rtl/p405s_litPkg.sv
// Literal sequencer shared definitions.
// Control encodings, class codes and state encoding.
package p405s_litPkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      STEP1 = 2'b01,
      STEP2 = 2'b10
   } litState_t;

   localparam logic [0:4] LIT_ZERO  = 5'b00100;
   localparam logic [0:4] LIT_SEXT  = 5'b10000;
   localparam logic [0:4] LIT_SHIFT = 5'b11100;
   localparam logic [0:4] LIT_UIMM  = 5'b00000;
   localparam logic [0:4] LIT_SPR   = 5'b00001;
   localparam logic [0:4] LIT_SMR   = 5'b00010;
   localparam logic [0:4] LIT_MSR1  = 5'b00101;
   localparam logic [0:4] LIT_MSR2  = 5'b01110;

   localparam logic [0:2] CLS_NONE   = 3'b000;
   localparam logic [0:2] CLS_SEXT   = 3'b001;
   localparam logic [0:2] CLS_SHIFT  = 3'b010;
   localparam logic [0:2] CLS_UIMM   = 3'b011;
   localparam logic [0:2] CLS_SPR    = 3'b100;
   localparam logic [0:2] CLS_SMR    = 3'b101;
   localparam logic [0:2] CLS_MSR    = 3'b110;
   localparam logic [0:2] CLS_DCRCLR = 3'b111;

   function automatic logic isTwoStep(input logic [0:2] cls);
      return (cls == CLS_MSR) || (cls == CLS_DCRCLR);
   endfunction

endpackage

// File: rtl/p405s_litSeqDcd.sv
// Literal class/step decoder.
// Maps (class, step) to the literal-control bus.
module p405s_litSeqDcd
   import p405s_litPkg::*;
(
   input  logic [0:2] litCls,
   input  logic       step2,
   output logic [0:4] cntl,
   output logic       twoStep
);

   // Pure lookup of the control word for the given step.
   always_comb begin
      cntl    = LIT_ZERO;
      twoStep = isTwoStep(litCls);
      unique case (litCls)
         CLS_NONE:   cntl = LIT_ZERO;
         CLS_SEXT:   cntl = LIT_SEXT;
         CLS_SHIFT:  cntl = LIT_SHIFT;
         CLS_UIMM:   cntl = LIT_UIMM;
         CLS_SPR:    cntl = LIT_SPR;
         CLS_SMR:    cntl = LIT_SMR;
         CLS_MSR:    cntl = step2 ? LIT_MSR2 : LIT_MSR1;
         CLS_DCRCLR: cntl = step2 ? LIT_ZERO : LIT_SPR;
         default:    cntl = LIT_ZERO;
      endcase
   end

endmodule

// File: rtl/p405s_litseqcntl.sv
// Execute-stage literal sequencer.
// Issues one or two literal-control steps per accepted request.
module p405s_litseqcntl
   import p405s_litPkg::*;
(
   input  logic       CB,
   input  logic       syncRstL,
   input  logic       dcdLitVal,
   input  logic [0:2] dcdLitOp,
   output logic       dcdLitAck,
   input  logic       exeHold,
   input  logic       exeFlush,
   output logic [0:4] litCntl,
   output logic       litVal,
   output logic       litLast
);

   litState_t  stateQ, stateD;
   logic [0:2] clsQ, clsD;
   logic [0:4] dcdCntl, cntlD;
   logic       twoStep, valD, lastD;
   logic       accept, start, frozen;

   // A non-idle step under hold is frozen; an idle
   // sequencer still takes requests it acknowledges.
   assign frozen = exeHold && (stateQ != IDLE);

   assign dcdLitAck = ~exeFlush
                    & ((stateQ == IDLE) | (litLast & ~exeHold));
   assign accept = dcdLitVal & dcdLitAck;
   assign start  = accept & (dcdLitOp != CLS_NONE);

   // Next state and class capture.
   always_comb begin
      stateD = stateQ;
      clsD   = clsQ;
      if (accept) clsD = dcdLitOp;
      if (exeFlush) begin
         stateD = IDLE;
      end else if (!frozen) begin
         unique case (stateQ)
            IDLE:    stateD = start ? STEP1 : IDLE;
            STEP1: begin
               if (isTwoStep(clsQ)) stateD = STEP2;
               else stateD = start ? STEP1 : IDLE;
            end
            STEP2:   stateD = start ? STEP1 : IDLE;
            default: stateD = IDLE;
         endcase
      end
   end

   p405s_litSeqDcd uDcd (
      .litCls  (clsD),
      .step2   (stateD == STEP2),
      .cntl    (dcdCntl),
      .twoStep (twoStep)
   );

   // Output values for the step that becomes current.
   always_comb begin
      cntlD = LIT_ZERO;
      valD  = 1'b0;
      lastD = 1'b0;
      if (stateD != IDLE) begin
         cntlD = dcdCntl;
         valD  = 1'b1;
         lastD = (stateD == STEP2) | ~twoStep;
      end
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge CB) begin
      if (!syncRstL) begin
         stateQ  <= IDLE;
         clsQ    <= CLS_NONE;
         litCntl <= LIT_ZERO;
         litVal  <= 1'b0;
         litLast <= 1'b0;
      end else begin
         stateQ  <= stateD;
         clsQ    <= clsD;
         litCntl <= cntlD;
         litVal  <= valD;
         litLast <= lastD;
      end
   end

endmodule

// File: tb/tb_p405s_litseqcntl.sv
// Bench for the literal sequencer.
// Vector table plus hand sequences, scoreboarded.
module tb_p405s_litseqcntl;

   logic       CB = 1'b0;
   logic       syncRstL;
   logic       dcdLitVal;
   logic [0:2] dcdLitOp;
   logic       dcdLitAck;
   logic       exeHold;
   logic       exeFlush;
   logic [0:4] litCntl;
   logic       litVal;
   logic       litLast;

   p405s_litseqcntl dut (
      .CB        (CB),
      .syncRstL  (syncRstL),
      .dcdLitVal (dcdLitVal),
      .dcdLitOp  (dcdLitOp),
      .dcdLitAck (dcdLitAck),
      .exeHold   (exeHold),
      .exeFlush  (exeFlush),
      .litCntl   (litCntl),
      .litVal    (litVal),
      .litLast   (litLast)
   );

   always #5 CB = ~CB;

   typedef struct {
      logic       rst;
      logic       val;
      logic [2:0] op;
      logic       hold;
      logic       flush;
      logic       ackChk;
      logic       ack;
      logic [4:0] cntl;
      logic       lv;
      logic       ll;
   } vec_t;

   typedef struct {
      logic [4:0] cntl;
      logic       lv;
      logic       ll;
      string      tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [4:0] Z  = 5'b00100;
   localparam logic [4:0] SX = 5'b10000;
   localparam logic [4:0] SH = 5'b11100;
   localparam logic [4:0] UI = 5'b00000;
   localparam logic [4:0] SP = 5'b00001;
   localparam logic [4:0] SM = 5'b00010;
   localparam logic [4:0] M1 = 5'b00101;
   localparam logic [4:0] M2 = 5'b01110;

   task automatic chk(input string name,
                      input logic [4:0] act,
                      input logic [4:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, req);
      end
   endtask

   task automatic addV(input logic r, input logic v,
                       input logic [2:0] op,
                       input logic h, input logic f,
                       input logic ac, input logic a,
                       input logic [4:0] cn,
                       input logic lv, input logic ll);
      vec_t x;
      x = '{r, v, op, h, f, ac, a, cn, lv, ll};
      vecs.push_back(x);
   endtask

   task automatic applyVec(input vec_t v, input string tag);
      exp_t e;
      @(negedge CB);
      syncRstL  = ~v.rst;
      dcdLitVal = v.val;
      dcdLitOp  = v.op;
      exeHold   = v.hold;
      exeFlush  = v.flush;
      #1;
      if (v.ackChk)
         chk({tag, " ack"}, {4'b0, dcdLitAck}, {4'b0, v.ack});
      e = '{v.cntl, v.lv, v.ll, tag};
      sbq.push_back(e);
      @(posedge CB);
      #1;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s sb: got empty want entry", tag);
      end else begin
         e = sbq.pop_front();
         chk({e.tag, " cntl"}, litCntl, e.cntl);
         chk({e.tag, " val"}, {4'b0, litVal}, {4'b0, e.lv});
         chk({e.tag, " last"}, {4'b0, litLast}, {4'b0, e.ll});
      end
   endtask

   initial begin
      vec_t hv;
      //   rst v  op     h  f  ac a  cntl lv ll
      addV(1, 0, 3'd0, 0, 0, 0, 0, Z,  0, 0);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      // back-to-back single-step classes
      addV(0, 1, 3'd1, 0, 0, 1, 1, SX, 1, 1);
      addV(0, 1, 3'd2, 0, 0, 1, 1, SH, 1, 1);
      addV(0, 1, 3'd3, 0, 0, 1, 1, UI, 1, 1);
      addV(0, 1, 3'd4, 0, 0, 1, 1, SP, 1, 1);
      addV(0, 1, 3'd5, 0, 0, 1, 1, SM, 1, 1);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      // mtmsr with two hold cycles in step 1
      addV(0, 1, 3'd6, 0, 0, 1, 1, M1, 1, 0);
      addV(0, 0, 3'd0, 1, 0, 1, 0, M1, 1, 0);
      addV(0, 0, 3'd0, 1, 0, 1, 0, M1, 1, 0);
      addV(0, 0, 3'd0, 0, 0, 1, 0, M2, 1, 1);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      // dcr clear flushed in step 1
      addV(0, 1, 3'd7, 0, 0, 1, 1, SP, 1, 0);
      addV(0, 0, 3'd0, 0, 1, 1, 0, Z,  0, 0);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      // class 000
      addV(0, 1, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      // hold+flush in step 2 with pending request
      addV(0, 1, 3'd7, 0, 0, 1, 1, SP, 1, 0);
      addV(0, 0, 3'd0, 0, 0, 1, 0, Z,  1, 1);
      addV(0, 1, 3'd1, 1, 1, 1, 0, Z,  0, 0);
      addV(0, 1, 3'd1, 0, 0, 1, 1, SX, 1, 1);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      // pending request waits through step 2 hold
      addV(0, 1, 3'd6, 0, 0, 1, 1, M1, 1, 0);
      addV(0, 1, 3'd1, 0, 0, 1, 0, M2, 1, 1);
      addV(0, 1, 3'd1, 1, 0, 1, 0, M2, 1, 1);
      addV(0, 1, 3'd1, 0, 0, 1, 1, SX, 1, 1);
      // reset mid step 1 of mtmsr
      addV(0, 1, 3'd6, 0, 0, 1, 1, M1, 1, 0);
      addV(1, 1, 3'd1, 0, 0, 1, 0, Z,  0, 0);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);
      // flush blocks a back-to-back accept
      addV(0, 1, 3'd4, 0, 0, 1, 1, SP, 1, 1);
      addV(0, 1, 3'd5, 0, 1, 1, 0, Z,  0, 0);
      addV(0, 0, 3'd0, 0, 0, 1, 1, Z,  0, 0);

      for (int i = 0; i < vecs.size(); i++)
         applyVec(vecs[i], $sformatf("v%0d", i));

      // dcr clear, step 2 held three cycles, then new op
      hv = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b0,
             1'b1, 1'b1, SP, 1'b1, 1'b0};
      applyVec(hv, "h0");
      for (int k = 0; k < 4; k++) begin
         hv = '{1'b0, 1'b1, 3'd3, (k != 0), 1'b0,
                1'b1, 1'b0, Z, 1'b1, 1'b1};
         applyVec(hv, $sformatf("h%0d", k + 1));
      end
      hv = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0,
             1'b1, 1'b1, UI, 1'b1, 1'b1};
      applyVec(hv, "h5");
      hv = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0,
             1'b1, 1'b1, Z, 1'b0, 1'b0};
      applyVec(hv, "h6");

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/p405s_litseqcntl.md
# p405s_litSeqCntl

Sequencer for the execute-stage literal generator. Accepts one decoded literal request per instruction from decode, drives the 5-bit literal-control bus (`litCntl[0:4]`) for one or two execute cycles, and holds that bus stable across execute stalls. Two-step literal ops are sequenced here so that decode can issue one request and then move on.

## Interface
Parameters: none. The encodings are fixed by the literal generator.

Ports:
- `CB` — in, 1 — core clock; all state updates on its rising edge.
- `syncRstL` — in, 1 — synchronous reset, active-low.
- `dcdLitVal` — in, 1 — decode presents a literal request.
- `dcdLitOp[0:2]` — in, 3 — literal class, sampled when `dcdLitVal & dcdLitAck`.
- `dcdLitAck` — out, 1 — sequencer accepts the request this cycle (combinational).
- `exeHold` — in, 1 — execute stall; freezes the current step.
- `exeFlush` — in, 1 — kill the in-flight sequence; has priority over everything except reset.
- `litCntl[0:4]` — out, 5 — registered control to the literal generator.
- `litVal` — out, 1 — registered; `litCntl` is meaningful this cycle.
- `litLast` — out, 1 — registered; current step is the final step of the op.

## Operation
Class → step 1 / step 2 `litCntl` (literal value in brackets):
- 000: no literal; accepted, no step issued.
- 001 sign-extended immediate: `10_000` [{16{imm[16]}}, imm].
- 010 shifted immediate: `11_100` [imm, 0x0000].
- 011 unsigned immediate: `00_000` [0x0000, imm].
- 100 spr/dcr address: `00_001`.
- 101 smr mask: `00_010`.
- 110 mtmsr: `00_101` [0x00000010], then `01_110` [0xFFFFFFEF].
- 111 dcr clear: `00_001`, then `00_100` [0x00000000].

State machine `{IDLE, STEP1, STEP2}`:
- IDLE + accept of classes 001–111 → STEP1; class 000 → stays IDLE.
- STEP1, `~exeHold`: two-step class → STEP2; single-step class → IDLE, or directly STEP1 if a back-to-back accept occurs.
- STEP2, `~exeHold` → IDLE, or STEP1 on back-to-back accept.
- Any state with `exeHold`: state and all outputs unchanged.
- `exeFlush`: next state is IDLE; `litVal=0`; `litCntl=00_100`; any same-cycle request is not accepted.

Register and ack rules:
- Class register captures `dcdLitOp` on accept only.
- `dcdLitAck = ~exeFlush & (IDLE | (litLast & ~exeHold))`.
- Idle / default output: `litCntl=00_100` (zero literal), `litVal=0`, `litLast=0`.

## Timing
- Reset (`syncRstL=0` at an edge): state=IDLE, `litCntl=00_100`, `litVal=0`, `litLast=0`. Reset wins over flush, hold and requests, including mid-sequence.
- Latency: request accepted at edge N → step 1 visible in cycle N+1. Step 2 follows one unheld cycle later.
- Throughput: one single-step op per cycle with no idle bubble between back-to-back accepts.
- Hold: each cycle with `exeHold=1` repeats the current step unchanged. `dcdLitAck=0` while holding a non-idle step.
- Flush during STEP1 of a two-step op: step 2 is never issued.
- Class 000 accepted: no `litVal` pulse; the outputs take the idle values.
- Simultaneous `exeHold` and `exeFlush`: flush wins.

## Structure
- Shared package `p405s_litPkg`: constants for the `litCntl` encodings (LIT_ZERO=`00_100`, LIT_SEXT=`10_000`, LIT_SHIFT=`11_100`, LIT_UIMM=`00_000`, LIT_SPR=`00_001`, LIT_SMR=`00_010`, LIT_MSR1=`00_101`, LIT_MSR2=`01_110`), the class codes, and the state encoding.
- One natural sub-module, `p405s_litSeqDcd`: combinational map of (class, step) → `litCntl`, two-step flag.

## Test plan
- Reset mid-STEP1 of class 110 → next cycle `litCntl=00_100`, `litVal=0`, state IDLE, `dcdLitAck=1`.
- Class 001, then 010, back-to-back with no hold → `litCntl=10_000` then `11_100` on consecutive cycles, `litLast=1` each, ack held at 1.
- Class 110 with `exeHold=1` for 2 cycles during step 1 → `00_101` held 3 cycles, then `01_110` for 1 cycle with `litLast=1`, then idle.
- Class 111 with `exeFlush` during step 1 → next cycle `litVal=0`, `litCntl=00_100`; `00_100` is never issued as step 2 with `litVal=1`.
- Class 000 request → accepted, `litVal` stays 0 and no state change.
- `exeHold` and `exeFlush` together in STEP2 with a pending request → flush wins, `dcdLitAck=0`, IDLE next cycle, request accepted on the following cycle.
